bank_sc: RTL and testbench

//  Bank storage controller, directly downstream of the bank issue stage. Accepts one

---
 rtl/bank_pkg.sv | 34 +++
 rtl/bank_sc_resp_fifo.sv | 59 +++++
 rtl/bank_sc.sv | 128 ++++++++++++
 tb/tb_bank_sc.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared types and constants for the bank storage controller.
package bank_pkg;

    localparam int unsigned SC_SWO_W      = 7;
    localparam int unsigned SC_DATA_W     = 128;
    localparam int unsigned SC_RESP_DEPTH = 2;

    localparam logic [2:0] SC_OP_WRITE = 3'd0;
    localparam logic [2:0] SC_OP_READ  = 3'd1;

    localparam logic [1:0] DIRTY_NONE  = 2'b00;
    localparam logic [1:0] DIRTY_CLEAN = 2'b01;
    localparam logic [1:0] DIRTY_SET   = 2'b10;

    typedef struct packed {
        logic [1:0]           channel_id;
        logic [7:0]           wbuffer_id;
        logic [2:0]           rob_num;
        logic [SC_DATA_W-1:0] data_offset0;
        logic [SC_DATA_W-1:0] data_offset1;
        logic [1:0]           dirty;
    } resp_t;

    // Any code other than DIRTY_NONE writes the data half.
    function automatic logic dirty_we(input logic [1:0] code);
        return code != DIRTY_NONE;
    endfunction

    // DIRTY_CLEAN clears the bit; DIRTY_SET and the 11 alias set it.
    function automatic logic dirty_val(input logic [1:0] code);
        return (code & DIRTY_SET) != DIRTY_NONE;
    endfunction

endpackage

// File: rtl/bank_sc_resp_fifo.sv
// Response FIFO: registered storage, head word presented straight from the array.
module bank_sc_resp_fifo
    import bank_pkg::*;
#(
    parameter int unsigned DEPTH = SC_RESP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  resp_t                      push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output resp_t                      pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    resp_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ready = (cnt != CNT_W'(DEPTH));
    assign pop_valid  = (cnt != '0);
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_valid & pop_ready;
    assign count      = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bank_sc.sv
// Bank storage controller: interleaved data/dirty arrays behind a credit-limited
// request channel, read responses returned in order through a small FIFO.
module bank_sc
    import bank_pkg::*;
#(
    parameter int unsigned SWO_W      = SC_SWO_W,
    parameter int unsigned DATA_W     = SC_DATA_W,
    parameter int unsigned RESP_DEPTH = SC_RESP_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              isu_sc_valid_i,
    output logic              isu_sc_ready_o,
    input  logic [1:0]        isu_sc_channel_id_i,
    input  logic [2:0]        isu_sc_opcode_i,
    input  logic [SWO_W-1:0]  isu_sc_set_way_offset_i,
    input  logic [7:0]        isu_sc_wbuffer_id_i,
    input  logic [2:0]        isu_sc_xbar_rob_num_i,
    input  logic [1:0]        isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]        isu_sc_cacheline_dirty_offset1_i,
    input  logic [DATA_W-1:0] isu_sc_linefill_data_offset0_i,
    input  logic [DATA_W-1:0] isu_sc_linefill_data_offset1_i,
    output logic              sc_xbar_valid_o,
    input  logic              sc_xbar_ready_i,
    output logic [1:0]        sc_xbar_channel_id_o,
    output logic [7:0]        sc_xbar_wbuffer_id_o,
    output logic [2:0]        sc_xbar_rob_num_o,
    output logic [DATA_W-1:0] sc_xbar_data_offset0_o,
    output logic [DATA_W-1:0] sc_xbar_data_offset1_o,
    output logic [1:0]        sc_xbar_dirty_o,
    output logic              sc_err_opcode_o
);

    localparam int unsigned IDX_W = SWO_W - 1;
    localparam int unsigned PAIRS = 1 << IDX_W;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    logic              accept;
    logic              is_write;
    logic              is_read;
    logic              is_rsvd;
    logic [IDX_W-1:0]  idx;
    logic              unused_offset_bit0;
    logic [DATA_W-1:0] mem_even [PAIRS];
    logic [DATA_W-1:0] mem_odd  [PAIRS];
    logic [PAIRS-1:0]  dirty_even;
    logic [PAIRS-1:0]  dirty_odd;
    logic              s1_valid;
    resp_t             s1_resp;
    logic              err_q;
    logic              push_ready;
    logic              head_valid;
    logic              pop_ready;
    resp_t             head;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credit_cnt;

    // Offsets are pair-aligned; the low bit only selects within the pair, which is accessed whole.
    assign idx                = isu_sc_set_way_offset_i[SWO_W-1:1];
    assign unused_offset_bit0 = isu_sc_set_way_offset_i[0];

    // A read holds a credit from acceptance until its response leaves the FIFO.
    assign credit_cnt     = fifo_count + CNT_W'(s1_valid);
    assign isu_sc_ready_o = ~rst_i & (credit_cnt < CNT_W'(RESP_DEPTH));

    assign accept   = isu_sc_valid_i & isu_sc_ready_o;
    assign is_write = accept & (isu_sc_opcode_i == SC_OP_WRITE);
    assign is_read  = accept & (isu_sc_opcode_i == SC_OP_READ);
    assign is_rsvd  = accept & (isu_sc_opcode_i != SC_OP_WRITE) & (isu_sc_opcode_i != SC_OP_READ);

    // Data array and read-stage payload; neither needs reset.
    always_ff @(posedge clk_i) begin
        if (is_write && dirty_we(isu_sc_cacheline_dirty_offset0_i))
            mem_even[idx] <= isu_sc_linefill_data_offset0_i;
        if (is_write && dirty_we(isu_sc_cacheline_dirty_offset1_i))
            mem_odd[idx] <= isu_sc_linefill_data_offset1_i;
        if (is_read) begin
            s1_resp.channel_id   <= isu_sc_channel_id_i;
            s1_resp.wbuffer_id   <= isu_sc_wbuffer_id_i;
            s1_resp.rob_num      <= isu_sc_xbar_rob_num_i;
            s1_resp.data_offset0 <= mem_even[idx];
            s1_resp.data_offset1 <= mem_odd[idx];
            s1_resp.dirty        <= {dirty_odd[idx], dirty_even[idx]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid   <= 1'b0;
            err_q      <= 1'b0;
            dirty_even <= '0;
            dirty_odd  <= '0;
        end else begin
            s1_valid <= is_read | (s1_valid & ~push_ready);
            err_q    <= is_rsvd;
            if (is_write && dirty_we(isu_sc_cacheline_dirty_offset0_i))
                dirty_even[idx] <= dirty_val(isu_sc_cacheline_dirty_offset0_i);
            if (is_write && dirty_we(isu_sc_cacheline_dirty_offset1_i))
                dirty_odd[idx] <= dirty_val(isu_sc_cacheline_dirty_offset1_i);
        end
    end

    bank_sc_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push_valid (s1_valid),
        .push_ready (push_ready),
        .push_data  (s1_resp),
        .pop_valid  (head_valid),
        .pop_ready  (pop_ready),
        .pop_data   (head),
        .count      (fifo_count)
    );

    // Stale state is still visible during the reset cycle itself, so mask it.
    assign pop_ready              = sc_xbar_ready_i & ~rst_i;
    assign sc_xbar_valid_o        = head_valid & ~rst_i;
    assign sc_err_opcode_o        = err_q & ~rst_i;
    assign sc_xbar_channel_id_o   = head.channel_id;
    assign sc_xbar_wbuffer_id_o   = head.wbuffer_id;
    assign sc_xbar_rob_num_o      = head.rob_num;
    assign sc_xbar_data_offset0_o = head.data_offset0;
    assign sc_xbar_data_offset1_o = head.data_offset1;
    assign sc_xbar_dirty_o        = head.dirty;

endmodule

// File: tb/tb_bank_sc.sv
// Self-checking bench for bank_sc: scenario tasks plus an in-order response scoreboard.
module tb_bank_sc;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         isu_sc_valid_i;
    logic         isu_sc_ready_o;
    logic [1:0]   isu_sc_channel_id_i;
    logic [2:0]   isu_sc_opcode_i;
    logic [6:0]   isu_sc_set_way_offset_i;
    logic [7:0]   isu_sc_wbuffer_id_i;
    logic [2:0]   isu_sc_xbar_rob_num_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset0_i;
    logic [1:0]   isu_sc_cacheline_dirty_offset1_i;
    logic [127:0] isu_sc_linefill_data_offset0_i;
    logic [127:0] isu_sc_linefill_data_offset1_i;
    logic         sc_xbar_valid_o;
    logic         sc_xbar_ready_i;
    logic [1:0]   sc_xbar_channel_id_o;
    logic [7:0]   sc_xbar_wbuffer_id_o;
    logic [2:0]   sc_xbar_rob_num_o;
    logic [127:0] sc_xbar_data_offset0_o;
    logic [127:0] sc_xbar_data_offset1_o;
    logic [1:0]   sc_xbar_dirty_o;
    logic         sc_err_opcode_o;

    always #5 clk = ~clk;

    bank_sc dut (
        .clk_i                            (clk),
        .rst_i                            (rst_i),
        .isu_sc_valid_i                   (isu_sc_valid_i),
        .isu_sc_ready_o                   (isu_sc_ready_o),
        .isu_sc_channel_id_i              (isu_sc_channel_id_i),
        .isu_sc_opcode_i                  (isu_sc_opcode_i),
        .isu_sc_set_way_offset_i          (isu_sc_set_way_offset_i),
        .isu_sc_wbuffer_id_i              (isu_sc_wbuffer_id_i),
        .isu_sc_xbar_rob_num_i            (isu_sc_xbar_rob_num_i),
        .isu_sc_cacheline_dirty_offset0_i (isu_sc_cacheline_dirty_offset0_i),
        .isu_sc_cacheline_dirty_offset1_i (isu_sc_cacheline_dirty_offset1_i),
        .isu_sc_linefill_data_offset0_i   (isu_sc_linefill_data_offset0_i),
        .isu_sc_linefill_data_offset1_i   (isu_sc_linefill_data_offset1_i),
        .sc_xbar_valid_o                  (sc_xbar_valid_o),
        .sc_xbar_ready_i                  (sc_xbar_ready_i),
        .sc_xbar_channel_id_o             (sc_xbar_channel_id_o),
        .sc_xbar_wbuffer_id_o             (sc_xbar_wbuffer_id_o),
        .sc_xbar_rob_num_o                (sc_xbar_rob_num_o),
        .sc_xbar_data_offset0_o           (sc_xbar_data_offset0_o),
        .sc_xbar_data_offset1_o           (sc_xbar_data_offset1_o),
        .sc_xbar_dirty_o                  (sc_xbar_dirty_o),
        .sc_err_opcode_o                  (sc_err_opcode_o)
    );

    typedef struct packed {
        logic [1:0]   ch;
        logic [7:0]   wb;
        logic [2:0]   rob;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [1:0]   dirty;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] m_even [64];
    logic [127:0] m_odd  [64];
    logic         m_de   [64];
    logic         m_do   [64];
    int           checks = 0;
    int           errors = 0;

    // Scoreboard: every handshaken response must match the oldest expected one.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (sc_xbar_valid_o && sc_xbar_ready_i) begin
            got = '{sc_xbar_channel_id_o, sc_xbar_wbuffer_id_o, sc_xbar_rob_num_o,
                    sc_xbar_data_offset0_o, sc_xbar_data_offset1_o, sc_xbar_dirty_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got rob=%0d, required no response", got.rob);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL resp_order: got ch=%0d wb=%0h rob=%0d d0=%0h d1=%0h dirty=%b, required ch=%0d wb=%0h rob=%0d d0=%0h d1=%0h dirty=%b",
                             got.ch, got.wb, got.rob, got.d0, got.d1, got.dirty,
                             e.ch, e.wb, e.rob, e.d0, e.d1, e.dirty);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        isu_sc_valid_i                   = 1'b0;
        isu_sc_channel_id_i              = '0;
        isu_sc_opcode_i                  = '0;
        isu_sc_set_way_offset_i          = '0;
        isu_sc_wbuffer_id_i              = '0;
        isu_sc_xbar_rob_num_i            = '0;
        isu_sc_cacheline_dirty_offset0_i = '0;
        isu_sc_cacheline_dirty_offset1_i = '0;
        isu_sc_linefill_data_offset0_i   = '0;
        isu_sc_linefill_data_offset1_i   = '0;
    endtask

    task automatic clear_model_dirty();
        for (int i = 0; i < 64; i++) begin
            m_de[i] = 1'b0;
            m_do[i] = 1'b0;
        end
    endtask

    // Model bookkeeping for a request being accepted this cycle.
    task automatic model_accept(input logic [2:0] op, input logic [6:0] off, input logic [1:0] ch,
                                input logic [7:0] wb, input logic [2:0] rob,
                                input logic [1:0] c0, input logic [1:0] c1,
                                input logic [127:0] d0, input logic [127:0] d1);
        logic [5:0] i;
        exp_t       e;
        i = off[6:1];
        if (op == 3'd1) begin
            e = '{ch, wb, rob, m_even[i], m_odd[i], {m_do[i], m_de[i]}};
            exp_q.push_back(e);
        end else if (op == 3'd0) begin
            if (c0 != 2'b00) begin
                m_even[i] = d0;
                m_de[i]   = (c0 != 2'b01);
            end
            if (c1 != 2'b00) begin
                m_odd[i] = d1;
                m_do[i]  = (c1 != 2'b01);
            end
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [6:0] off, input logic [1:0] ch,
                         input logic [7:0] wb, input logic [2:0] rob,
                         input logic [1:0] c0, input logic [1:0] c1,
                         input logic [127:0] d0, input logic [127:0] d1);
        isu_sc_valid_i                   = 1'b1;
        isu_sc_opcode_i                  = op;
        isu_sc_set_way_offset_i          = off;
        isu_sc_channel_id_i              = ch;
        isu_sc_wbuffer_id_i              = wb;
        isu_sc_xbar_rob_num_i            = rob;
        isu_sc_cacheline_dirty_offset0_i = c0;
        isu_sc_cacheline_dirty_offset1_i = c1;
        isu_sc_linefill_data_offset0_i   = d0;
        isu_sc_linefill_data_offset1_i   = d1;
    endtask

    // Present one request until accepted; returns in the cycle after acceptance.
    task automatic send(input logic [2:0] op, input logic [6:0] off, input logic [1:0] ch,
                        input logic [7:0] wb, input logic [2:0] rob,
                        input logic [1:0] c0, input logic [1:0] c1,
                        input logic [127:0] d0, input logic [127:0] d1);
        int budget = 0;
        drive(op, off, ch, wb, rob, c0, c1, d0, d1);
        while (!isu_sc_ready_o && budget < 50) begin
            sc_xbar_ready_i = 1'b1;
            cyc();
            budget++;
        end
        checks++;
        if (isu_sc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL send_accept_timeout: ready_o=%b after %0d cycles, required 1", isu_sc_ready_o, budget);
        end else begin
            model_accept(op, off, ch, wb, rob, c0, c1, d0, d1);
        end
        cyc();
        idle();
    endtask

    task automatic drain(input string name);
        sc_xbar_ready_i = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        sc_xbar_ready_i = 1'b1;
        idle();
        clear_model_dirty();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (isu_sc_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: cycle %0d got %b, required 0", i, isu_sc_ready_o);
            end
            checks++;
            if (sc_xbar_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: cycle %0d got %b, required 0", i, sc_xbar_valid_o);
            end
            checks++;
            if (sc_err_opcode_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_err: cycle %0d got %b, required 0", i, sc_err_opcode_o);
            end
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (isu_sc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", isu_sc_ready_o);
        end
        cyc();
    endtask

    task automatic test_write_read();
        sc_xbar_ready_i = 1'b1;
        send(3'd0, 7'd4, 2'd0, 8'h00, 3'd0, 2'b10, 2'b01, 128'd100, 128'd101);
        checks++;
        if (sc_err_opcode_o !== 1'b0) begin
            errors++;
            $display("FAIL write_no_err: got %b, required 0", sc_err_opcode_o);
        end
        send(3'd1, 7'd4, 2'd1, 8'h5a, 3'd3, 2'b00, 2'b00, 128'd0, 128'd0);
        checks++;
        if (sc_xbar_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency_t1: valid got %b, required 0", sc_xbar_valid_o);
        end
        cyc();
        checks++;
        if (sc_xbar_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rd_latency_t2: valid got %b, required 1", sc_xbar_valid_o);
        end
        checks++;
        if (sc_xbar_data_offset0_o !== 128'd100 || sc_xbar_data_offset1_o !== 128'd101) begin
            errors++;
            $display("FAIL rd_data: got %0d/%0d, required 100/101", sc_xbar_data_offset0_o, sc_xbar_data_offset1_o);
        end
        checks++;
        if (sc_xbar_dirty_o !== 2'b01) begin
            errors++;
            $display("FAIL rd_dirty: got %b, required 01", sc_xbar_dirty_o);
        end
        checks++;
        if (sc_xbar_channel_id_o !== 2'd1 || sc_xbar_wbuffer_id_o !== 8'h5a || sc_xbar_rob_num_o !== 3'd3) begin
            errors++;
            $display("FAIL rd_tags: got ch=%0d wb=%0h rob=%0d, required ch=1 wb=5a rob=3",
                     sc_xbar_channel_id_o, sc_xbar_wbuffer_id_o, sc_xbar_rob_num_o);
        end
        cyc();
        checks++;
        if (sc_xbar_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_popped: valid got %b, required 0", sc_xbar_valid_o);
        end
    endtask

    task automatic test_credit();
        sc_xbar_ready_i = 1'b1;
        send(3'd0, 7'd6,  2'd0, 8'h00, 3'd0, 2'b01, 2'b10, 128'd600,  128'd601);
        send(3'd0, 7'd10, 2'd0, 8'h00, 3'd0, 2'b11, 2'b01, 128'd1000, 128'd1001);
        sc_xbar_ready_i = 1'b0;
        drive(3'd1, 7'd4, 2'd2, 8'h10, 3'd0, 2'b00, 2'b00, 128'd0, 128'd0);
        checks++;
        if (isu_sc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL credit_rd0_ready: got %b, required 1", isu_sc_ready_o);
        end
        model_accept(3'd1, 7'd4, 2'd2, 8'h10, 3'd0, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        drive(3'd1, 7'd6, 2'd2, 8'h11, 3'd1, 2'b00, 2'b00, 128'd0, 128'd0);
        checks++;
        if (isu_sc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL credit_rd1_ready: got %b, required 1", isu_sc_ready_o);
        end
        model_accept(3'd1, 7'd6, 2'd2, 8'h11, 3'd1, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        drive(3'd1, 7'd10, 2'd2, 8'h12, 3'd2, 2'b00, 2'b00, 128'd0, 128'd0);
        checks++;
        if (isu_sc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_full: ready got %b, required 0", isu_sc_ready_o);
        end
        cyc();
        checks++;
        if (isu_sc_ready_o !== 1'b0 || sc_xbar_valid_o !== 1'b1 || sc_xbar_rob_num_o !== 3'd0) begin
            errors++;
            $display("FAIL credit_hold: ready=%b valid=%b rob=%0d, required ready=0 valid=1 rob=0",
                     isu_sc_ready_o, sc_xbar_valid_o, sc_xbar_rob_num_o);
        end
        cyc();
        checks++;
        if (sc_xbar_rob_num_o !== 3'd0 || sc_xbar_data_offset0_o !== 128'd100) begin
            errors++;
            $display("FAIL credit_stable: rob=%0d d0=%0d, required rob=0 d0=100", sc_xbar_rob_num_o, sc_xbar_data_offset0_o);
        end
        sc_xbar_ready_i = 1'b1;
        checks++;
        if (isu_sc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_no_bypass: ready got %b, required 0", isu_sc_ready_o);
        end
        cyc();
        sc_xbar_ready_i = 1'b0;
        checks++;
        if (isu_sc_ready_o !== 1'b1 || sc_xbar_rob_num_o !== 3'd1) begin
            errors++;
            $display("FAIL credit_freed: ready=%b rob=%0d, required ready=1 rob=1", isu_sc_ready_o, sc_xbar_rob_num_o);
        end
        model_accept(3'd1, 7'd10, 2'd2, 8'h12, 3'd2, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        idle();
        checks++;
        if (isu_sc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_refull: ready got %b, required 0", isu_sc_ready_o);
        end
        drain("credit");
    endtask

    task automatic test_no_write_codes();
        sc_xbar_ready_i = 1'b1;
        send(3'd0, 7'd8, 2'd0, 8'h00, 3'd0, 2'b01, 2'b01, 128'd200, 128'd201);
        send(3'd0, 7'd8, 2'd0, 8'h00, 3'd0, 2'b00, 2'b00, 128'd300, 128'd301);
        send(3'd1, 7'd8, 2'd3, 8'h20, 3'd4, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        checks++;
        if (sc_xbar_valid_o !== 1'b1 || sc_xbar_data_offset0_o !== 128'd200 ||
            sc_xbar_data_offset1_o !== 128'd201 || sc_xbar_dirty_o !== 2'b00) begin
            errors++;
            $display("FAIL nowrite_keep: valid=%b d=%0d/%0d dirty=%b, required valid=1 d=200/201 dirty=00",
                     sc_xbar_valid_o, sc_xbar_data_offset0_o, sc_xbar_data_offset1_o, sc_xbar_dirty_o);
        end
        send(3'd0, 7'd13, 2'd0, 8'h00, 3'd0, 2'b11, 2'b10, 128'd555, 128'd556);
        send(3'd1, 7'd12, 2'd0, 8'h21, 3'd5, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        checks++;
        if (sc_xbar_data_offset0_o !== 128'd555 || sc_xbar_data_offset1_o !== 128'd556 || sc_xbar_dirty_o !== 2'b11) begin
            errors++;
            $display("FAIL pair_align_dirty11: d=%0d/%0d dirty=%b, required d=555/556 dirty=11",
                     sc_xbar_data_offset0_o, sc_xbar_data_offset1_o, sc_xbar_dirty_o);
        end
        drain("nowrite");
    endtask

    task automatic test_reserved();
        sc_xbar_ready_i = 1'b1;
        send(3'd5, 7'd8, 2'd1, 8'h30, 3'd6, 2'b10, 2'b10, 128'd999, 128'd998);
        checks++;
        if (sc_err_opcode_o !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_err_pulse: got %b, required 1", sc_err_opcode_o);
        end
        cyc();
        checks++;
        if (sc_err_opcode_o !== 1'b0 || sc_xbar_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_quiet: err=%b valid=%b, required err=0 valid=0", sc_err_opcode_o, sc_xbar_valid_o);
        end
        send(3'd1, 7'd8, 2'd1, 8'h31, 3'd7, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        checks++;
        if (sc_xbar_data_offset0_o !== 128'd200 || sc_xbar_dirty_o !== 2'b00) begin
            errors++;
            $display("FAIL rsvd_no_effect: d0=%0d dirty=%b, required d0=200 dirty=00", sc_xbar_data_offset0_o, sc_xbar_dirty_o);
        end
        drain("rsvd");
    endtask

    task automatic test_reset_mid();
        sc_xbar_ready_i = 1'b0;
        send(3'd1, 7'd4,  2'd0, 8'h40, 3'd5, 2'b00, 2'b00, 128'd0, 128'd0);
        send(3'd1, 7'd12, 2'd0, 8'h41, 3'd6, 2'b00, 2'b00, 128'd0, 128'd0);
        sc_xbar_ready_i = 1'b0;
        rst_i = 1'b1;
        exp_q.delete();
        clear_model_dirty();
        #1;
        checks++;
        if (sc_xbar_valid_o !== 1'b0 || isu_sc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b ready=%b, required 0/0", sc_xbar_valid_o, isu_sc_ready_o);
        end
        cyc();
        rst_i = 1'b0;
        sc_xbar_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (sc_xbar_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_discard: cycle %0d valid=%b rob=%0d, required valid=0", i, sc_xbar_valid_o, sc_xbar_rob_num_o);
            end
        end
        send(3'd1, 7'd12, 2'd2, 8'h42, 3'd7, 2'b00, 2'b00, 128'd0, 128'd0);
        cyc();
        checks++;
        if (sc_xbar_valid_o !== 1'b1 || sc_xbar_dirty_o !== 2'b00 || sc_xbar_data_offset0_o !== 128'd555) begin
            errors++;
            $display("FAIL midreset_dirty_clear: valid=%b dirty=%b d0=%0d, required valid=1 dirty=00 d0=555",
                     sc_xbar_valid_o, sc_xbar_dirty_o, sc_xbar_data_offset0_o);
        end
        drain("midreset");
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [6:0] off;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = 3'd1;
                2, 3:    op = 3'd0;
                default: op = 3'($urandom_range(2, 7));
            endcase
            off = 7'({$urandom_range(2, 6), 1'($urandom_range(0, 1))});
            sc_xbar_ready_i = 1'($urandom_range(0, 1));
            send(op, off, 2'($urandom_range(0, 3)), 8'($urandom), 3'(i),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 {96'd0, 32'($urandom)}, {96'd0, 32'($urandom)});
        end
        drain("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_even[i] = '0;
            m_odd[i]  = '0;
        end
        test_reset();
        test_write_read();
        test_credit();
        test_no_write_codes();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
